// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Constants shared by the UART transmitter and receiver: line levels for
//   idle/start/stop, default frame geometry and the receiver state encoding.
//   No ports; imported with "import uart_pkg::*;".
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam logic IDLE_BIT  = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic END_BIT   = 1'b1;

  localparam int DEFAULT_WIDTH        = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input bit. Both flops
//   reset to RESET_VAL so the synchronized output shows a known level (e.g.
//   an idle serial line) straight out of reset.
// Ports
//   i_clk    in   1   sampling clock
//   i_rst_n  in   1   asynchronous active-low reset
//   i_d      in   1   asynchronous input
//   o_q      out  1   synchronized output, two clocks behind i_d
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= RESET_VAL;
      o_q  <= RESET_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1-style UART receiver. The line is synchronized, the start bit is
//   qualified at its midpoint, then each data bit (LSB first) and the stop
//   bit are sampled one bit period apart. Good frames land in a one-entry
//   output register with a valid/ready handshake; a bad stop bit raises a
//   frame-error pulse and a frame arriving while the register is still full
//   is dropped with an overrun pulse.
// Ports
//   i_clk        in   1      system clock, rising edge
//   i_rst_n      in   1      asynchronous active-low reset
//   i_uart_rx    in   1      asynchronous serial line, idles high
//   o_data       out  WIDTH  received byte, stable while o_valid is high
//   o_valid      out  1      byte available, held until accepted
//   i_ready      in   1      consumer takes o_data when o_valid && i_ready
//   o_frame_err  out  1      one-cycle pulse: stop bit sampled low
//   o_overrun    out  1      one-cycle pulse: frame dropped, register full
//   o_busy       out  1      receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_WIDTH    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_uart_rx,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_frame_err,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] BIT_LAST  = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(WIDTH - 1);

  logic                 rx_s;
  rx_state_e            state, state_next;
  logic [CNT_WIDTH-1:0] timer, timer_next;
  logic [IDX_W-1:0]     bit_idx, bit_idx_next;
  logic [WIDTH-1:0]     shift;
  logic                 sample_bit;
  logic                 stop_good;
  logic                 stop_bad;
  logic                 accept;

  sync_2ff #(
    .RESET_VAL (IDLE_BIT)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_uart_rx),
    .o_q     (rx_s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      bit_idx <= bit_idx_next;
    end
  end

  // The start bit is checked half a bit in, so every later sample taken a
  // full bit period apart falls near the middle of its bit.
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    bit_idx_next = bit_idx;
    sample_bit   = 1'b0;
    stop_good    = 1'b0;
    stop_bad     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_s == START_BIT) begin
          state_next = START;
          timer_next = '0;
        end
      end
      START: begin
        if (timer == HALF_LAST) begin
          timer_next = '0;
          if (rx_s == IDLE_BIT) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      DATA: begin
        if (timer == BIT_LAST) begin
          timer_next = '0;
          sample_bit = 1'b1;
          if (bit_idx == IDX_LAST) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      STOP: begin
        if (timer == BIT_LAST) begin
          timer_next = '0;
          if (rx_s == END_BIT) begin
            stop_good  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // A low stop bit may be a break; never restart until the line idles.
        if (rx_s == IDLE_BIT) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift <= '0;
    end else if (sample_bit) begin
      shift[bit_idx] <= rx_s;
    end
  end

  assign accept = o_valid && i_ready;

  // A byte accepted on the same edge a new frame completes frees the
  // register in time, so the new byte loads and o_valid stays high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (stop_good && (!o_valid || accept)) begin
        o_data  <= shift;
        o_valid <= 1'b1;
      end else if (accept) begin
        o_valid <= 1'b0;
      end
      o_overrun   <= stop_good && o_valid && !accept;
      o_frame_err <= stop_bad;
    end
  end

  assign o_busy = (state != IDLE);

`ifdef FORMAL
  always @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (timer <= BIT_LAST);
      assert (bit_idx <= IDX_LAST);
    end
  end
`endif

endmodule
